// File: rtl/apb_cdc_pkg.sv
// Shared types and parameter defaults for the asynchronous-request APB master bridge.
package apb_cdc_pkg;

    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ACK_UP = 2'd3
    } apb_cdc_state_e;

endpackage

// File: rtl/apb_cdc_sync.sv
// Reset-to-zero flop chain that brings a single asynchronous level into the clk domain.
module apb_cdc_sync
    import apb_cdc_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/apb_slave_asynch_ext.sv
// Turns a 4-phase req/ack request from another clock domain into one APB4 master transfer.
// Optional ACCESS timeout abort is compiled in with APB_ASYNCH_TIMEOUT_EN.
module apb_slave_asynch_ext
    import apb_cdc_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [APB_ADDR_WIDTH-1:0]     PADDR_o,
    output logic [APB_DATA_WIDTH-1:0]     PWDATA_o,
    output logic                          PWRITE_o,
    output logic                          PSEL_o,
    output logic                          PENABLE_o,
    output logic [2:0]                    PPROT_o,
    output logic [APB_DATA_WIDTH/8-1:0]   PSTRB_o,
    input  logic [APB_DATA_WIDTH-1:0]     PRDATA_i,
    input  logic                          PREADY_i,
    input  logic                          PSLVERR_i,
    input  logic                          asynch_req_i,
    output logic                          asynch_ack_o,
    input  logic [APB_ADDR_WIDTH-1:0]     async_PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0]     async_PWDATA_i,
    input  logic                          async_PWRITE_i,
    input  logic                          async_PSEL_i,
    input  logic [2:0]                    async_PPROT_i,
    input  logic [APB_DATA_WIDTH/8-1:0]   async_PSTRB_i,
    output logic [APB_DATA_WIDTH-1:0]     async_PRDATA_o,
    output logic                          async_PSLVERR_o,
    output logic                          timeout_o
);

    localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2 || (APB_DATA_WIDTH % 8) != 0) begin : g_param_err
        $error("apb_slave_asynch_ext: illegal parameter value");
    end

    apb_cdc_state_e              state_q, state_d;
    logic                        req_sync;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                        pwrite_q, pwrite_d;
    logic [2:0]                  pprot_q, pprot_d;
    logic [STRB_W-1:0]           pstrb_q, pstrb_d;
    logic                        psel_q, psel_d;
    logic                        penable_q, penable_d;
    logic                        ack_q, ack_d;
    logic [APB_DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                        pslverr_q, pslverr_d;

    apb_cdc_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (asynch_req_i),
        .q_o   (req_sync)
    );

`ifdef APB_ASYNCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pprot_q   <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pprot_q   <= pprot_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ack_q     <= ack_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Bus strobes and ack are decoded from the next state so they leave flops.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pprot_d   = pprot_q;
        pstrb_d   = pstrb_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
`ifdef APB_ASYNCH_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_sync) begin
                    paddr_d  = async_PADDR_i;
                    pwdata_d = async_PWDATA_i;
                    pwrite_d = async_PWRITE_i;
                    pprot_d  = async_PPROT_i;
                    pstrb_d  = async_PSTRB_i;
                    if (async_PSEL_i) begin
                        state_d = SETUP;
                    end else begin
                        prdata_d  = '0;
                        pslverr_d = 1'b0;
                        state_d   = ACK_UP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_ASYNCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (PREADY_i) begin
                    prdata_d  = PRDATA_i;
                    pslverr_d = PSLVERR_i;
                    state_d   = ACK_UP;
                end
`ifdef APB_ASYNCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ACK_UP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ACK_UP: begin
                if (!req_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        ack_d     = (state_d == ACK_UP);
    end

    assign PADDR_o         = paddr_q;
    assign PWDATA_o        = pwdata_q;
    assign PWRITE_o        = pwrite_q;
    assign PPROT_o         = pprot_q;
    assign PSTRB_o         = pstrb_q;
    assign PSEL_o          = psel_q;
    assign PENABLE_o       = penable_q;
    assign asynch_ack_o    = ack_q;
    assign async_PRDATA_o  = prdata_q;
    assign async_PSLVERR_o = pslverr_q;

endmodule

// File: tb/tb_apb_slave_asynch_ext.sv
// Directed bench for apb_slave_asynch_ext: transaction timeline model plus per-cycle compare.
module tb_apb_slave_asynch_ext;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SYNC = 2;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   PADDR_o;
    logic [DW-1:0]   PWDATA_o;
    logic            PWRITE_o, PSEL_o, PENABLE_o;
    logic [2:0]      PPROT_o;
    logic [DW/8-1:0] PSTRB_o;
    logic [DW-1:0]   PRDATA_i;
    logic            PREADY_i, PSLVERR_i;
    logic            asynch_req_i, asynch_ack_o;
    logic [AW-1:0]   async_PADDR_i;
    logic [DW-1:0]   async_PWDATA_i;
    logic            async_PWRITE_i, async_PSEL_i;
    logic [2:0]      async_PPROT_i;
    logic [DW/8-1:0] async_PSTRB_i;
    logic [DW-1:0]   async_PRDATA_o;
    logic            async_PSLVERR_o, timeout_o;

    apb_slave_asynch_ext #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PADDR_o         (PADDR_o),
        .PWDATA_o        (PWDATA_o),
        .PWRITE_o        (PWRITE_o),
        .PSEL_o          (PSEL_o),
        .PENABLE_o       (PENABLE_o),
        .PPROT_o         (PPROT_o),
        .PSTRB_o         (PSTRB_o),
        .PRDATA_i        (PRDATA_i),
        .PREADY_i        (PREADY_i),
        .PSLVERR_i       (PSLVERR_i),
        .asynch_req_i    (asynch_req_i),
        .asynch_ack_o    (asynch_ack_o),
        .async_PADDR_i   (async_PADDR_i),
        .async_PWDATA_i  (async_PWDATA_i),
        .async_PWRITE_i  (async_PWRITE_i),
        .async_PSEL_i    (async_PSEL_i),
        .async_PPROT_i   (async_PPROT_i),
        .async_PSTRB_i   (async_PSTRB_i),
        .async_PRDATA_o  (async_PRDATA_o),
        .async_PSLVERR_o (async_PSLVERR_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected output values, advanced by the transaction timeline
    logic [AW-1:0]   exp_paddr = '0;
    logic [DW-1:0]   exp_pwdata = '0;
    logic            exp_pwrite = 1'b0;
    logic [2:0]      exp_pprot = '0;
    logic [DW/8-1:0] exp_pstrb = '0;
    logic            exp_psel = 1'b0, exp_pen = 1'b0, exp_ack = 1'b0;
    logic [DW-1:0]   exp_prdata = '0;
    logic            exp_slverr = 1'b0, exp_timeout = 1'b0;

    // Observed per-transaction statistics
    int ack_at, ack_n, psel_n, pen_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("PADDR_o", 64'(PADDR_o), 64'(exp_paddr));
        chk("PWDATA_o", 64'(PWDATA_o), 64'(exp_pwdata));
        chk("PWRITE_o", 64'(PWRITE_o), 64'(exp_pwrite));
        chk("PPROT_o", 64'(PPROT_o), 64'(exp_pprot));
        chk("PSTRB_o", 64'(PSTRB_o), 64'(exp_pstrb));
        chk("PSEL_o", 64'(PSEL_o), 64'(exp_psel));
        chk("PENABLE_o", 64'(PENABLE_o), 64'(exp_pen));
        chk("asynch_ack_o", 64'(asynch_ack_o), 64'(exp_ack));
        chk("async_PRDATA_o", 64'(async_PRDATA_o), 64'(exp_prdata));
        chk("async_PSLVERR_o", 64'(async_PSLVERR_o), 64'(exp_slverr));
        chk("timeout_o", 64'(timeout_o), 64'(exp_timeout));
    end

    // Cycle c counts clock edges after req rises (or reset releases with req held).
    // req_sync is high after edge SYNC, capture at SYNC+1, ack when ACCESS completes,
    // ack falls SYNC+1 edges after req drops but never before one ack cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input logic sel,
                        input int w, input logic [31:0] rdata, input logic slverr,
                        input logic early, input int rst_c);
        int   rise, d, fall, c, rc;
        logic abort;
        abort = 1'b0;
        rc    = rst_c;
        if (!sel) begin
            rise = 3;
        end else begin
            rise = 5 + w;
`ifdef APB_ASYNCH_TIMEOUT_EN
            if (w >= int'(TO)) begin
                abort = 1'b1;
                rise  = 4 + int'(TO);
            end
`endif
        end
        d    = early ? 3 : rise;
        fall = (d + int'(SYNC) + 1 > rise + 1) ? d + int'(SYNC) + 1 : rise + 1;
        ack_at = -1; ack_n = 0; psel_n = 0; pen_n = 0;

        @(posedge clk); #1;
        async_PWRITE_i = wr;   async_PADDR_i = addr; async_PWDATA_i = wdata;
        async_PSTRB_i  = strb; async_PPROT_i = prot; async_PSEL_i   = sel;
        PRDATA_i = rdata; PSLVERR_i = slverr; PREADY_i = (w == 0);
        asynch_req_i = 1'b1;
        c = 0;
        while (c <= fall) begin
            @(posedge clk); #1;
            c++;
            if (asynch_ack_o) begin
                ack_n++;
                if (ack_at < 0) ack_at = c;
            end
            if (PSEL_o)    psel_n++;
            if (PENABLE_o) pen_n++;
            if (c == 3) begin
                exp_paddr = addr; exp_pwdata = wdata; exp_pwrite = wr;
                exp_pprot = prot; exp_pstrb  = strb;
            end
            exp_psel = sel && c >= 3 && c < rise;
            exp_pen  = sel && c >= 4 && c < rise;
            exp_ack  = c >= rise && c < fall;
            if (c == rise) begin
                exp_prdata = (sel && !abort) ? rdata : 32'h0;
                exp_slverr = sel && (abort || slverr);
                if (abort) exp_timeout = 1'b1;
            end
            PREADY_i = (w == 0) || (c == 4 + w);
            if (c == d) asynch_req_i = 1'b0;
            if (c == rc) begin
                #2 rst_n = 1'b0;
                exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0; exp_pprot = '0;
                exp_pstrb = '0; exp_psel = 1'b0; exp_pen = 1'b0; exp_ack = 1'b0;
                exp_prdata = '0; exp_slverr = 1'b0; exp_timeout = 1'b0;
                #1;
                chk("rst_async_psel", 64'(PSEL_o), 64'd0);
                chk("rst_async_penable", 64'(PENABLE_o), 64'd0);
                chk("rst_async_paddr", 64'(PADDR_o), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                c = 0; rc = -1;
                ack_at = -1; ack_n = 0; psel_n = 0; pen_n = 0;
            end
        end
        PREADY_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; asynch_req_i = 1'b0;
        async_PADDR_i = '0; async_PWDATA_i = '0; async_PWRITE_i = 1'b0;
        async_PSEL_i = 1'b0; async_PPROT_i = '0; async_PSTRB_i = '0;
        PRDATA_i = '0; PREADY_i = 1'b0; PSLVERR_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero-wait write: ack 3 cycles after req_sync (cycle 2)
        xfer(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b000, 1'b1, 0, 32'h0BADF00D, 1'b0, 1'b0, -1);
        chk("wr_ack_latency", 64'(ack_at), 64'd5);
        chk("wr_psel_cycles", 64'(psel_n), 64'd2);
        chk("wr_penable_cycles", 64'(pen_n), 64'd1);
        chk("wr_ack_cycles", 64'(ack_n), 64'd3);
        chk("wr_pslverr", 64'(async_PSLVERR_o), 64'd0);
        chk("wr_paddr", 64'(PADDR_o), 64'h1000);

        // Read with 5 wait states and slave error
        xfer(1'b0, 32'h2004, 32'h0, 4'h0, 3'b010, 1'b1, 5, 32'h12345678, 1'b1, 1'b0, -1);
        chk("rd_ack_latency", 64'(ack_at), 64'd10);
        chk("rd_penable_cycles", 64'(pen_n), 64'd6);
        chk("rd_prdata", 64'(async_PRDATA_o), 64'h12345678);
        chk("rd_pslverr", 64'(async_PSLVERR_o), 64'd1);

        // No-select request: no bus cycle, zero response
        xfer(1'b1, 32'h3000, 32'h55AA55AA, 4'h3, 3'b001, 1'b0, 0, 32'hFFFFFFFF, 1'b1, 1'b0, -1);
        chk("nosel_psel_cycles", 64'(psel_n), 64'd0);
        chk("nosel_ack_latency", 64'(ack_at), 64'd3);
        chk("nosel_prdata", 64'(async_PRDATA_o), 64'd0);
        chk("nosel_pslverr", 64'(async_PSLVERR_o), 64'd0);

        // req dropped before ack: transfer completes, single-cycle ack
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'b0101, 3'b101, 1'b1, 0, 32'hCAFE0001, 1'b0, 1'b1, -1);
        chk("early_ack_cycles", 64'(ack_n), 64'd1);
        chk("early_prdata", 64'(async_PRDATA_o), 64'hCAFE0001);

        // Top address, empty strobe, two wait states
        xfer(1'b1, 32'hFFFFFFFC, 32'h0000_0001, 4'h0, 3'b111, 1'b1, 2, 32'h8000_0000, 1'b0, 1'b0, -1);
        chk("top_ack_latency", 64'(ack_at), 64'd7);
        chk("top_pprot", 64'(PPROT_o), 64'd7);

`ifdef APB_ASYNCH_TIMEOUT_EN
        // Slave never ready: abort after TO ACCESS cycles
        xfer(1'b0, 32'h5000, 32'h0, 4'hF, 3'b000, 1'b1, 100, 32'h11111111, 1'b0, 1'b0, -1);
        chk("to_ack_latency", 64'(ack_at), 64'd12);
        chk("to_penable_cycles", 64'(pen_n), 64'd8);
        chk("to_pslverr", 64'(async_PSLVERR_o), 64'd1);
        chk("to_prdata", 64'(async_PRDATA_o), 64'd0);
        chk("to_flag", 64'(timeout_o), 64'd1);
        // Ready in the last allowed cycle wins; flag stays sticky
        xfer(1'b0, 32'h5004, 32'h0, 4'hF, 3'b000, 1'b1, 7, 32'h22222222, 1'b0, 1'b0, -1);
        chk("to_edge_prdata", 64'(async_PRDATA_o), 64'h22222222);
        chk("to_edge_pslverr", 64'(async_PSLVERR_o), 64'd0);
        chk("to_edge_flag_sticky", 64'(timeout_o), 64'd1);
`endif

        // Reset in ACCESS, req held: fresh transfer after release
        xfer(1'b0, 32'h6000, 32'h0, 4'hF, 3'b000, 1'b1, 6, 32'hA5A5F00F, 1'b0, 1'b0, 5);
        chk("rst_ack_latency", 64'(ack_at), 64'd11);
        chk("rst_prdata", 64'(async_PRDATA_o), 64'hA5A5F00F);
        chk("rst_timeout_cleared", 64'(timeout_o), 64'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_asynch_ext.md
APB_SLAVE_ASYNCH_EXT -- requirements
Module: apb_slave_asynch_ext

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, req synchroniser depth; minimum 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS cycles before abort; minimum 2.
REQ-005 SHALL have port clk  in  1  destination clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports PADDR_o/PWDATA_o/PWRITE_o/PSEL_o/PENABLE_o  out  ADDR/DATA/1/1/1  APB master request.
REQ-008 SHALL have ports PPROT_o  out  3 and PSTRB_o  out  DATA/8, both APB4 attributes.
REQ-009 SHALL have ports PRDATA_i/PREADY_i/PSLVERR_i  in  DATA/1/1  APB response.
REQ-010 SHALL have ports asynch_req_i  in  1 and asynch_ack_o  out  1, the 4-phase handshake.
REQ-011 SHALL have ports async_PADDR_i/async_PWDATA_i/async_PWRITE_i/async_PSEL_i/async_PPROT_i/async_PSTRB_i  in, widths matching the APB outputs; held stable by the source while req is high.
REQ-012 SHALL have ports async_PRDATA_o  out  DATA, async_PSLVERR_o  out  1 and timeout_o  out  1 (sticky abort flag).

Function
REQ-013 SHALL synchronise asynch_req_i through SYNC_STAGES flops into req_sync; no other async input is synchronised.
REQ-014 SHALL implement states IDLE, SETUP, ACCESS, ACK_UP.
REQ-015 IDLE with req_sync=1: SHALL capture all async_* request fields into the APB output registers; go SETUP if captured PSEL=1, else go ACK_UP with async_PRDATA_o='0 and async_PSLVERR_o=0 (no bus cycle).
REQ-016 SETUP: PSEL_o=1, PENABLE_o=0 for exactly one cycle; then ACCESS.
REQ-017 ACCESS: PSEL_o=1, PENABLE_o=1; on PREADY_i=1 SHALL capture PRDATA_i/PSLVERR_i into async_PRDATA_o/async_PSLVERR_o and go ACK_UP.
REQ-018 PSEL_o and PENABLE_o SHALL be 0 in IDLE and ACK_UP; PADDR/PWDATA/PWRITE/PPROT/PSTRB SHALL hold their last captured values until the next capture.
REQ-019 asynch_ack_o SHALL be driven from a flop, high exactly while in ACK_UP, glitch-free.
REQ-020 ACK_UP: stay while req_sync=1; on req_sync=0 go IDLE and drop ack on the same edge.
REQ-021 async_PRDATA_o/async_PSLVERR_o SHALL be stable from ack rise until the next capture.
REQ-022 Minimum latency req_sync rise to ack rise with zero-wait slave: 3 clk cycles (SETUP, ACCESS, ACK_UP).
REQ-023 req falling before ack (protocol violation): transfer SHALL complete; ACK_UP then exits after one cycle (one-cycle ack pulse).

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, all sync flops 0, and every output to 0, including mid-transfer.
REQ-025 After reset release, a req already high SHALL start a new transfer after SYNC_STAGES cycles.

Configuration
REQ-026 With APB_ASYNCH_TIMEOUT_EN defined: SHALL count ACCESS cycles ($clog2(TIMEOUT_CYCLES+1) bits, cleared on entering ACCESS); at count TIMEOUT_CYCLES-1 with PREADY_i=0, SHALL go ACK_UP with async_PRDATA_o='0, async_PSLVERR_o=1, and set timeout_o until reset.
REQ-027 PREADY_i=1 in the timeout cycle SHALL win: normal completion, no abort.
REQ-028 Without APB_ASYNCH_TIMEOUT_EN: no counter; ACCESS waits indefinitely; timeout_o tied 0.

Structure
REQ-029 Package apb_cdc_pkg SHALL hold the state enum type and the SYNC_STAGES/TIMEOUT_CYCLES defaults.
REQ-030 Sub-module apb_cdc_sync (parametrised flop chain, reset 0) SHALL implement the req synchroniser.

Verification
REQ-031 Write, PADDR=0x1000, PWDATA=0xDEADBEEF, PSTRB=0xF, PREADY tied 1 -> one SETUP and one ACCESS cycle; ack high 3 cycles after req_sync; PSLVERR_o=0.
REQ-032 Read at 0x2004, PREADY after 5 wait cycles, PRDATA=0x12345678, PSLVERR=1 -> async_PRDATA_o=0x12345678, async_PSLVERR_o=1 at ack rise.
REQ-033 async_PSEL_i=0 with req -> no PSEL_o pulse; ack with PRDATA_o=0, PSLVERR_o=0.
REQ-034 APB_ASYNCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY held 0 -> abort after 8 ACCESS cycles; PSLVERR_o=1, timeout_o=1; same with PREADY=1 in cycle 8 -> normal completion.
REQ-035 rst_n asserted in ACCESS -> outputs 0 immediately; after release, held req -> fresh transfer completes normally.
